// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_sequencer
// Description : Per-sample coefficient fetch sequencer for a transposed FIR.
//               Shares one single-port coefficient SRAM between host writes
//               and the tap-read sequence. Each accepted sample reads taps
//               0..NUM_TAP-1 and streams them with tap index and
//               accumulator-clear markers.
//               Optional macro HOST_FAIR_EN: alternate the IDLE grant between
//               host and sample when both are pending, instead of strict
//               sample priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_sequencer #(
  parameter int NUM_TAP = 33,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iInValid,
  output logic              oInReady,
  input  logic              iHostWrReq,
  input  logic [ADDR_W-1:0] iHostAddr,
  input  logic [DATA_W-1:0] iHostWrDt,
  output logic              oHostAck,
  output logic              oHostErr,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic [DATA_W-1:0] oCoeff,
  output logic              oCoeffValid,
  output logic [ADDR_W-1:0] oTapIdx,
  output logic              oClrAcc,
  output logic              oSampleDone
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_write = 3'd1;
  localparam logic [2:0] c_read  = 3'd2;
  localparam logic [2:0] c_drain = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  localparam logic [ADDR_W-1:0] c_last_tap = ADDR_W'(NUM_TAP - 1);
  localparam logic [ADDR_W:0]   c_num_tap  = (ADDR_W + 1)'(NUM_TAP);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hdata_q, hdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic              host_first;
  logic              sample_go;
  logic              host_go;
  logic              addr_ok;

  // Out-of-range host addresses are acknowledged with an error, never written.
  assign addr_ok = ({1'b0, haddr_q} < c_num_tap);

`ifdef HOST_FAIR_EN
  logic last_host_q, last_host_d;

  // Host jumps the queue only if the previous IDLE grant went to a sample.
  assign host_first = iHostWrReq && !last_host_q;

  // Track which requester won the most recent IDLE grant.
  always_comb begin
    last_host_d = last_host_q;
    if (state_q == c_idle) begin
      if (sample_go)    last_host_d = 1'b0;
      else if (host_go) last_host_d = 1'b1;
    end
  end

  // Last-grant register; resets to "host" so the first tie goes to a sample.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) last_host_q <= 1'b1;
    else      last_host_q <= last_host_d;
  end
`else
  assign host_first = 1'b0;
`endif

  assign sample_go = iInValid && !host_first;
  assign host_go   = iHostWrReq && !sample_go;

  // State register.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) state_q <= c_idle;
    else      state_q <= state_d;
  end

  // Next-state logic, tap counter and host request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    unique case (state_q)
      c_idle: begin
        if (sample_go) begin
          state_d = c_read;
          cnt_d   = '0;
        end else if (host_go) begin
          state_d = c_write;
          haddr_d = iHostAddr;
          hdata_d = iHostWrDt;
        end
      end
      c_write: state_d = c_idle;
      c_read: begin
        if (cnt_q == c_last_tap) begin
          state_d = c_drain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_drain: state_d = c_done;
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Output decode from the registered state; RAM bus is zeroed when idle.
  always_comb begin
    oInReady    = 1'b0;
    oHostAck    = 1'b0;
    oHostErr    = 1'b0;
    oCsnRam     = 1'b1;
    oWrnRam     = 1'b1;
    oAddrRam    = '0;
    oWrDtRam    = '0;
    oSampleDone = 1'b0;
    unique case (state_q)
      c_idle: oInReady = 1'b1;
      c_write: begin
        oHostAck = 1'b1;
        if (addr_ok) begin
          oCsnRam  = 1'b0;
          oWrnRam  = 1'b0;
          oAddrRam = haddr_q;
          oWrDtRam = hdata_q;
        end else begin
          oHostErr = 1'b1;
        end
      end
      c_read: begin
        oCsnRam  = 1'b0;
        oAddrRam = cnt_q;
      end
      c_done:  oSampleDone = 1'b1;
      default: ;
    endcase
  end

  // Read strobe and address delayed by the SRAM read latency.
  always_comb begin
    rd_vld_d = (state_q == c_read);
    tap_d    = (state_q == c_read) ? cnt_q : '0;
  end

  // Datapath registers.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      cnt_q    <= '0;
      haddr_q  <= '0;
      hdata_q  <= '0;
      rd_vld_q <= 1'b0;
      tap_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      haddr_q  <= haddr_d;
      hdata_q  <= hdata_d;
      rd_vld_q <= rd_vld_d;
      tap_q    <= tap_d;
    end
  end

  assign oCoeffValid = rd_vld_q;
  assign oTapIdx     = tap_q;
  assign oClrAcc     = rd_vld_q && (tap_q == '0);
  assign oCoeff      = rd_vld_q ? iRdDtRam : '0;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_coeff_sequencer
// Description : Directed bench for fir_coeff_sequencer with a behavioural
//               single-port SRAM and a coefficient scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_sequencer;

  localparam int NUM_TAP = 33;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ack;
  logic              host_err;
  logic              csn;
  logic              wrn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] coeff;
  logic              coeff_valid;
  logic [ADDR_W-1:0] tap_idx;
  logic              clr_acc;
  logic              sample_done;

  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] exp_coef [0:NUM_TAP-1];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fir_coeff_sequencer #(.NUM_TAP(NUM_TAP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .iClk_12M   (clk),
    .iRst       (rst),
    .iInValid   (in_valid),
    .oInReady   (in_ready),
    .iHostWrReq (host_req),
    .iHostAddr  (host_addr),
    .iHostWrDt  (host_data),
    .oHostAck   (host_ack),
    .oHostErr   (host_err),
    .oCsnRam    (csn),
    .oWrnRam    (wrn),
    .oAddrRam   (ram_addr),
    .oWrDtRam   (ram_wdata),
    .iRdDtRam   (ram_rdata),
    .oCoeff     (coeff),
    .oCoeffValid(coeff_valid),
    .oTapIdx    (tap_idx),
    .oClrAcc    (clr_acc),
    .oSampleDone(sample_done)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (!csn) begin
      if (!wrn) mem[ram_addr] <= ram_wdata;
      else      ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host write starting in an IDLE cycle; ack expected in the following cycle.
  task automatic host_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic err);
    host_req  = 1'b1;
    host_addr = a;
    host_data = d;
    chk("wr_idle_ack", {31'd0, host_ack}, 32'd0);
    tick;
    host_req = 1'b0;
    chk("wr_ack", {31'd0, host_ack}, 32'd1);
    chk("wr_err", {31'd0, host_err}, {31'd0, err});
    chk("wr_csn", {31'd0, csn}, {31'd0, err});
    chk("wr_wrn", {31'd0, wrn}, {31'd0, err});
    chk("wr_addr", {26'd0, ram_addr}, err ? 32'd0 : {26'd0, a});
    chk("wr_data", {16'd0, ram_wdata}, err ? 32'd0 : {16'd0, d});
    if (!err) exp_coef[a] = d;
    tick;
    chk("wr_after_ack", {31'd0, host_ack}, 32'd0);
    chk("wr_after_csn", {31'd0, csn}, 32'd1);
  endtask

  // One full sample sequence from an IDLE cycle T through T+NUM_TAP+3.
  task automatic do_sample;
    in_valid = 1'b1;
    chk("smp_ready", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("smp_t1_valid", {31'd0, coeff_valid}, 32'd0);
    chk("smp_t1_csn", {31'd0, csn}, 32'd0);
    for (int k = 0; k < NUM_TAP; k++) begin
      tick;
      chk("tap_valid", {31'd0, coeff_valid}, 32'd1);
      chk("tap_idx", {26'd0, tap_idx}, k);
      chk("tap_coeff", {16'd0, coeff}, {16'd0, exp_coef[k]});
      chk("tap_clr", {31'd0, clr_acc}, (k == 0) ? 32'd1 : 32'd0);
      chk("tap_done", {31'd0, sample_done}, 32'd0);
    end
    tick;
    chk("done_pulse", {31'd0, sample_done}, 32'd1);
    chk("done_valid", {31'd0, coeff_valid}, 32'd0);
    chk("done_coeff", {16'd0, coeff}, 32'd0);
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_done", {31'd0, sample_done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc;
    int dones;
    int exp_ack;
    int exp_dones;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < NUM_TAP; i++) exp_coef[i] = '0;
    ram_rdata = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    host_req  = 1'b0;
    host_addr = '0;
    host_data = '0;
    #1;
    // Reset state.
    chk("rst_csn", {31'd0, csn}, 32'd1);
    chk("rst_wrn", {31'd0, wrn}, 32'd1);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, coeff_valid}, 32'd0);
    chk("rst_ack", {31'd0, host_ack}, 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Preload taps with 100..132.
    for (int a = 0; a < NUM_TAP; a++) host_wr(a[ADDR_W-1:0], DATA_W'(100 + a), 1'b0);

    // Full sample readback.
    do_sample;

    // Out-of-range host write.
    chk("err_pre_csn", {31'd0, csn}, 32'd1);
    host_wr(6'd40, 16'hDEAD, 1'b1);

    // Host request raised mid-sequence is deferred to after DONE.
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 2; c <= 36; c++) begin
      tick;
      if (c == 5) begin
        host_req  = 1'b1;
        host_addr = 6'd7;
        host_data = 16'h7777;
      end
      chk("defer_no_ack", {31'd0, host_ack}, 32'd0);
      chk("defer_no_wr", {31'd0, wrn}, 32'd1);
    end
    chk("defer_ready", {31'd0, in_ready}, 32'd1);
    tick;
    host_req = 1'b0;
    chk("defer_ack", {31'd0, host_ack}, 32'd1);
    chk("defer_wrn", {31'd0, wrn}, 32'd0);
    chk("defer_addr", {26'd0, ram_addr}, 32'd7);
    exp_coef[7] = 16'h7777;
    tick;
    do_sample;

    // Back-to-back samples with a pending host write.
`ifdef HOST_FAIR_EN
    exp_ack   = 37;
    exp_dones = 1;
`else
    exp_ack   = 109;
    exp_dones = 3;
`endif
    ack_cyc  = -1;
    dones    = 0;
    in_valid = 1'b1;
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 300 && ack_cyc < 0; c++) begin
      tick;
      if (c == 1) begin
        host_req  = 1'b1;
        host_addr = 6'd3;
        host_data = 16'h0333;
      end
      if (sample_done) dones++;
      if (host_ack) begin
        ack_cyc  = c;
        host_req = 1'b0;
        chk("b2b_wr_addr", {26'd0, ram_addr}, 32'd3);
        chk("b2b_wrn", {31'd0, wrn}, 32'd0);
      end
      if (dones >= 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("b2b_ack_cycle", ack_cyc, exp_ack);
    chk("b2b_dones", dones, exp_dones);
    exp_coef[3] = 16'h0333;
    tick;
    chk("b2b_idle", {31'd0, in_ready}, 32'd1);
    do_sample;

    // Asynchronous reset at tap 10.
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 2; c <= 12; c++) tick;
    chk("pre_rst_tap", {26'd0, tap_idx}, 32'd10);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, coeff_valid}, 32'd0);
    chk("arst_tap", {26'd0, tap_idx}, 32'd0);
    chk("arst_coeff", {16'd0, coeff}, 32'd0);
    chk("arst_csn", {31'd0, csn}, 32'd1);
    chk("arst_addr", {26'd0, ram_addr}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("arst_no_done", {31'd0, sample_done}, 32'd0);
    end
    rst = 1'b0;
    tick;
    do_sample;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
